// File: rtl/uart_pkg.sv
// Shared UART constants used by the receiver, transmitter and RX FIFO.
// Pointer width helper gives one extra wrap bit beyond the address width.
package uart_pkg;

    localparam int UART_DBITS         = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port DEPTH x DBITS storage: registered write, asynchronous read.
// Contents are intentionally not reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DBITS = UART_DBITS,
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DBITS-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [DBITS-1:0] rdata
);

    logic [DBITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO behind the UART receiver with sticky overrun.
// Define UART_RX_FIFO_LEVEL_EN to add a registered occupancy output 'level'.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DBITS = UART_DBITS,
    parameter int DEPTH = UART_RX_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_done,
    input  logic [DBITS-1:0] rx_dout,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [DBITS-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             overrun,
    input  logic             clr_overrun
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    output logic [ptr_width(DEPTH)-1:0] level
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic          rx_done_q;
    logic          push, pop, wr_en, drop;
    logic          empty_i, full_i, overrun_q;
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;

    // Edge-detect so a long rx_done produces exactly one push.
    assign push = rx_done && !rx_done_q;

    assign empty_i = (wr_ptr == rd_ptr);
    assign full_i  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // Flags read as their reset values for the whole time rst is high.
    assign rd_valid = !empty_i && !rst;
    assign empty    = !rd_valid;
    assign full     = full_i && !rst;
    assign overrun  = overrun_q && !rst;

    assign pop = rd_valid && rd_ready;
    // A push while full is still accepted when the head leaves in the same cycle.
    assign wr_en = push && !rst && (!full_i || pop);
    assign drop  = push && full_i && !pop;

    assign wr_ptr_nx = wr_en ? wr_ptr + PW'(1) : wr_ptr;
    assign rd_ptr_nx = pop   ? rd_ptr + PW'(1) : rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rx_done_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nx;
            rd_ptr    <= rd_ptr_nx;
            rx_done_q <= rx_done;
            if (drop)             overrun_q <= 1'b1;
            else if (clr_overrun) overrun_q <= 1'b0;
        end
    end

    uart_fifo_mem #(
        .DBITS(DBITS),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_en),
        .waddr(wr_ptr[AW-1:0]),
        .wdata(rx_dout),
        .raddr(rd_ptr[AW-1:0]),
        .rdata(rd_data)
    );

`ifdef UART_RX_FIFO_LEVEL_EN
    logic [PW-1:0] level_q;

    always_ff @(posedge clk) begin
        if (rst) level_q <= '0;
        else     level_q <= wr_ptr_nx - rd_ptr_nx;
    end

    assign level = rst ? '0 : level_q;
`endif

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DBITS, default 8, meaning the byte width and matching the receiver's data width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of FIFO entries; legal values are powers of 2 that are 2 or greater.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port rx_done, input, 1 bit: receiver frame-complete indication, which may stay high for more than one cycle.
REQ-006 SHALL have port rx_dout, input, DBITS bits: received byte, stable while rx_done is high.
REQ-007 SHALL have port rd_valid, output, 1 bit: the FIFO head is valid.
REQ-008 SHALL have port rd_ready, input, 1 bit: the consumer accepts the head.
REQ-009 SHALL have port rd_data, output, DBITS bits: the FIFO head (first-word-fall-through).
REQ-010 SHALL have port full, output, 1 bit: all DEPTH entries are occupied.
REQ-011 SHALL have port empty, output, 1 bit: no entries are occupied; always equals !rd_valid.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag indicating a byte was dropped.
REQ-013 SHALL have port clr_overrun, input, 1 bit: single-cycle clear of overrun.

Function
REQ-014 SHALL register rx_done into rx_done_q and generate push = rx_done & !rx_done_q, so that exactly one push occurs per rx_done high period.
REQ-015 SHALL sample rx_dout in the same cycle as push.
REQ-016 SHALL generate pop = rd_valid & rd_ready; with rd_valid low, rd_ready is ignored.
REQ-017 SHALL use write and read pointers of clog2(DEPTH)+1 bits each, addressing storage with the low clog2(DEPTH) bits so that pointers wrap naturally.
REQ-018 SHALL assert empty when the pointers are equal, and assert full when the low bits are equal and the MSBs differ.
REQ-019 SHALL present a byte pushed at edge N on rd_data, with rd_valid high, after edge N when the FIFO was empty; write-to-read latency is 1 cycle.
REQ-020 SHALL hold rd_data stable while rd_valid is high and rd_ready is low.
REQ-021 SHALL, on push and pop in the same cycle while not full and not empty, perform both operations and leave occupancy unchanged.
REQ-022 SHALL, on push while full together with a pop, accept the push, so that the FIFO remains full and no byte is dropped.
REQ-023 SHALL, on push while full without a pop, discard the byte, leave storage and pointers unchanged, and set overrun at the next edge.
REQ-024 SHALL, on push while empty, ignore any rd_ready in that cycle; the byte becomes visible the following cycle.
REQ-025 SHALL clear overrun on clr_overrun; if a new overrun event and clr_overrun coincide, set wins.
REQ-026 SHALL not reset storage contents; only pointers and flags are reset.

Reset
REQ-027 SHALL, while rst is high, drive wr_ptr=0, rd_ptr=0, rx_done_q=0, overrun=0, rd_valid=0, empty=1, full=0, and level=0 when present.
REQ-028 SHALL, on rst asserted mid-operation, discard all queued bytes at the next edge, with no push or pop taking effect in that cycle.
REQ-029 SHALL, when rx_done is high during the first cycle after reset release, register it as a single push.

Configuration
REQ-030 SHALL, with macro UART_RX_FIFO_LEVEL_EN defined, add output level [clog2(DEPTH):0] equal to wr_ptr-rd_ptr, registered and updated in the same edge as the pointers.
REQ-031 SHALL, without UART_RX_FIFO_LEVEL_EN, have no level port and no level logic; all other behaviour is identical.

Structure
REQ-032 SHALL take the constants UART_DBITS=8, UART_RX_FIFO_DEPTH=16 and a function computing pointer width from shared package uart_pkg, which is also used by the receiver and transmitter.
REQ-033 SHALL place storage in sub-module uart_fifo_mem, a simple dual-port DEPTH x DBITS memory with registered write and asynchronous read.

Verification
REQ-034 SHALL verify single push: an rx_done pulse of 1 cycle with rx_dout=0xA5 gives rd_valid=1 and rd_data=0xA5 at the next cycle; rd_ready=1 then gives empty=1.
REQ-035 SHALL verify a long rx_done: rx_done held high for 16 cycles with 0x3C gives exactly one entry, with level=1 when the macro is defined.
REQ-036 SHALL verify fill and overrun: 16 pushes (0x00..0x0F) with rd_ready=0 give full=1; a 17th push of 0xFF gives overrun=1, and draining returns 0x00..0x0F in order with 0xFF absent.
REQ-037 SHALL verify push and pop while full: with the FIFO full and pop and push (0x77) in the same cycle, full stays 1, no overrun occurs, and 0x77 is the last entry read.
REQ-038 SHALL verify wrap-around: 40 bytes streamed with rd_ready=1 continuously are all read in order, with overrun=0.
REQ-039 SHALL verify reset mid-operation and the set-over-clear rule: with 5 bytes queued, asserting rst for 1 cycle gives empty=1 and overrun=0; separately, clr_overrun coinciding with an overrun event leaves overrun=1.
